// File: rtl/lsu_mem_port_pkg.sv
// Shared types for the load/store unit memory port: access-size encodings
// (funct3), FSM state encoding and small size-decode helpers.
package lsu_mem_port_pkg;

    typedef enum logic [2:0] {
        LOAD_BYTE          = 3'b000,
        LOAD_HALF          = 3'b001,
        LOAD_WORD          = 3'b010,
        LOAD_DOUBLE        = 3'b011,
        LOAD_BYTE_UNSIGNED = 3'b100,
        LOAD_HALF_UNSIGNED = 3'b101,
        LOAD_WORD_UNSIGNED = 3'b110
    } load_type_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010,
        SD = 3'b011
    } store_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    localparam int WAIT_CNT_W = 16;

    // Low-offset bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    size_mask = 3'b000;
            2'd1:    size_mask = 3'b001;
            2'd2:    size_mask = 3'b011;
            default: size_mask = 3'b111;
        endcase
    endfunction

    // Byte-enable pattern of an access at lane offset zero.
    function automatic logic [7:0] be_base(input logic [1:0] size);
        case (size)
            2'd0:    be_base = 8'h01;
            2'd1:    be_base = 8'h03;
            2'd2:    be_base = 8'h0F;
            default: be_base = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_port_load_extend.sv
// Load data extraction: shifts the addressed bytes down to bit 0 and
// sign- or zero-extends them to XLEN according to the load funct3.
module lsu_load_extend
    import lsu_mem_port_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]           rdata,
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  logic [2:0]                funct3,
    output logic [XLEN-1:0]           data
);

    logic [XLEN-1:0]    shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] word_s;

    assign shifted = rdata >> {offset, 3'b000};
    assign byte_s  = shifted[7:0];
    assign half_s  = shifted[15:0];
    assign word_s  = shifted[31:0];

    // Size casts of signed operands replicate the sign bit.
    always_comb begin
        data = '0;
        case (funct3)
            LOAD_BYTE:          data = XLEN'(byte_s);
            LOAD_HALF:          data = XLEN'(half_s);
            LOAD_WORD:          data = XLEN'(word_s);
            LOAD_DOUBLE:        data = shifted;
            LOAD_BYTE_UNSIGNED: data = XLEN'(shifted[7:0]);
            LOAD_HALF_UNSIGNED: data = XLEN'(shifted[15:0]);
            LOAD_WORD_UNSIGNED: data = XLEN'(shifted[31:0]);
            default:            data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit towards a valid/ready data-memory port. One transaction in
// flight: IDLE -> REQ -> WAIT -> RESP, with a watchdog on WAIT.
// Optional build macro MISALIGN_TRAP_EN: misaligned accesses fault without a
// memory request; otherwise the offset is masked down to size alignment.
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_fault
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

    lsu_state_t state, state_nxt;

    logic [WAIT_CNT_W-1:0] wait_cnt, cnt_inc;
    logic                  timeout;
    logic                  fault_q;

    logic [1:0]       req_size;
    logic [OFF_W-1:0] req_off, req_mask, req_off_eff;
    logic             req_illegal, req_fault;
    logic [NB-1:0]    req_be;

    logic             we_q;
    logic [2:0]       funct3_q;
    logic [4:0]       rd_q;
    logic [XLEN-1:0]  addr_q, wdata_q, data_q, load_data;
    logic [NB-1:0]    be_q;
    logic [OFF_W-1:0] off_q;

    // Store data copied into every lane of its own size.
    function automatic logic [XLEN-1:0] replicate(input logic [XLEN-1:0] d,
                                                  input logic [1:0] size);
        case (size)
            2'd0:    replicate = {NB{d[7:0]}};
            2'd1:    replicate = {(NB/2){d[15:0]}};
            2'd2:    replicate = {(XLEN/32){d[31:0]}};
            default: replicate = d;
        endcase
    endfunction

    // Request decode: size legality, alignment handling and byte enables.
    always_comb begin
        req_size = req_funct3[1:0];
        req_off  = req_addr[OFF_W-1:0];
        req_mask = OFF_W'(size_mask(req_size));
        if (req_we)
            req_illegal = (XLEN == 64) ? (req_funct3 >= 3'd4) : (req_funct3 >= 3'd3);
        else
            req_illegal = (req_funct3 == 3'b111) ||
                          ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
`ifdef MISALIGN_TRAP_EN
        req_off_eff = req_off;
        req_fault   = req_illegal || ((req_off & req_mask) != '0);
`else
        req_off_eff = req_off & ~req_mask;
        req_fault   = req_illegal;
`endif
        req_be = NB'(be_base(req_size)) << req_off_eff;
    end

    assign cnt_inc = wait_cnt + 1'b1;
    assign timeout = (cnt_inc == MAX_WAIT_C);

    lsu_load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata  (mem_rdata),
        .offset (off_q),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Watchdog counter and fault flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) fault_q <= req_fault;
                REQ:  if (mem_req_ready) wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= cnt_inc;
                    if (mem_rsp_valid) fault_q <= 1'b0;
                    else if (timeout)  fault_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Transaction data: latched on accept, load result captured on response.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            rd_q     <= req_rd;
            addr_q   <= {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            be_q     <= req_be;
            wdata_q  <= replicate(req_wdata, req_size);
            off_q    <= req_off_eff;
            data_q   <= '0;
        end else if (state == WAIT && mem_rsp_valid) begin
            data_q   <= we_q ? '0 : load_data;
        end
    end

    // Next-state logic and state-decoded outputs; data outputs gated to zero
    // outside their owning state.
    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_be        = '0;
        mem_wdata     = '0;
        rsp_valid     = 1'b0;
        rsp_data      = '0;
        rsp_rd        = '0;
        rsp_fault     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_fault ? RESP : REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                mem_we        = we_q;
                mem_addr      = addr_q;
                mem_be        = be_q;
                mem_wdata     = wdata_q;
                if (mem_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_rsp_valid || timeout) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = data_q;
                rsp_rd    = rd_q;
                rsp_fault = fault_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Parametrised load/store unit between the execute stage and a valid/ready data-memory port.
- Takes one load or store per transaction, selected by funct3:
  - load sizes as in load_type_t;
  - stores SB/SH/SW, plus SD when XLEN=64.
- Generates word-aligned address, byte enables and lane-replicated write data; sign/zero-extends load data.
- Returns one response per request. Bounded-wait watchdog converts a hung memory into a fault.

Parameters:
- XLEN, 32, datapath/address width; legal values 32 or 64.
- MAX_WAIT, 255, cycles in WAIT before timeout fault; 1..2^16-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  unit can accept (high only in IDLE).
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  access size/sign (load_type_t / store_type_t).
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, LSB-justified.
- req_rd  in  5  destination tag, returned unchanged.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts.
- mem_we  out  1  write strobe.
- mem_addr  out  XLEN  address, low log2(XLEN/8) bits zero.
- mem_be  out  XLEN/8  byte enables.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_rsp_valid  in  1  read data / write ack.
- mem_rdata  in  XLEN  read data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  XLEN  extended load data (0 for stores and faults).
- rsp_rd  out  5  tag of the response.
- rsp_fault  out  1  access fault, qualified by rsp_valid.

Behaviour:
- Reset:
  - state=IDLE, wait counter=0.
  - All outputs 0 except req_ready=1.
  - Reset at any point returns to IDLE; a mem_rsp_valid arriving afterwards is ignored (no rsp_valid).
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/funct3/addr/wdata/rd; compute be and replicated wdata; go to REQ.
  - Illegal size, always faulting and never touching memory: store funct3>=3 (>=4 when XLEN=64); load 011/110 when XLEN=32; 111 always. Illegal size goes to RESP with fault=1.
  - mem_rsp_valid is ignored in IDLE.
- REQ:
  - mem_req_valid=1; addr/be/wdata/we held stable until mem_req_ready.
  - Handshake → WAIT, counter cleared.
- WAIT:
  - counter++ each cycle.
  - mem_rsp_valid → capture extended data (loads) → RESP, fault=0. Stores need the ack too.
  - counter==MAX_WAIT with no rsp → RESP, fault=1, data=0.
  - If mem_rsp_valid and timeout coincide, the response wins.
- RESP: rsp_valid=1 for exactly one cycle; no backpressure; next state IDLE.
- Latency: accept at cycle 0; mem_req_valid from cycle 1; if ready at cycle 1 and rsp at cycle 2, rsp_valid at cycle 3. Minimum 3 cycles, one transaction in flight.
- Byte-enable rule: offset o=addr[log2(XLEN/8)-1:0]; be = ({1,3,F,FF} by size) << o.
- Write-data replication: byte copied to every lane, half to every half, word to every word.
- Load extraction: mem_rdata >> (8*o), truncated to size; signed sizes sign-extend from the MSB of the accessed size, U variants zero-fill.

Optional Feature:
- MISALIGN_TRAP_EN defined: access with o not a multiple of size → no memory request, one-cycle RESP with fault=1, data=0.
- Not defined: o is masked down to size alignment (aligned access, no fault).

Decomposition:
- Pkg additions:
  - store_type_t (SB=000, SH=001, SW=010, SD=011);
  - load_type_t extended with LOAD_DOUBLE=011 and LOAD_WORD_UNSIGNED=110;
  - lsu_state_t (IDLE/REQ/WAIT/RESP).
- Sub-module lsu_load_extend: combinational offset shift + sign/zero extension, parametrised by XLEN.

Test Plan:
- LB addr 0x1003, mem_rdata 0x80FF0000 → mem_addr 0x1000, be 1000, rsp_data 0xFFFFFF80; repeat as LBU → 0x00000080.
- SH addr 0x1002, wdata 0x1234ABCD → mem_be 1100, mem_wdata 0xABCDABCD, mem_we=1; ack → rsp_valid, rsp_data 0, fault 0.
- mem_req_ready low 5 cycles → mem_req_valid/addr/be stable, req_ready=0 throughout; ready → rsp_valid exactly once.
- MAX_WAIT=4, no mem_rsp_valid → rsp_valid with rsp_fault=1 after 4 WAIT cycles; next request accepted normally.
- LW addr 0x1002: with MISALIGN_TRAP_EN → fault, mem_req_valid never asserted; without → mem_addr 0x1000, be 1111, fault 0.
- rst asserted in WAIT, mem_rsp_valid pulses next cycle → all outputs 0, req_ready=1, no rsp_valid; funct3=111 load → immediate fault, no memory request.
